uart_rx_frame_fsm: RTL and testbench

Parametrised receive-frame controller for the UART Rx core. It tracks start, data, parity and stop bits from the shift register's synchronisation pulses and supports 5–9 data bits, five parity modes and 1 or 2 stop bits. It checks parity and stop bits itself and recovers from a stalled frame with an acquisition-tick watchdog. It sits between the Rx shift register / baudrate generator and the Rx control registers.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_tmr_vote.sv | 14 +
 rtl/uart_rx_frame_fsm.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_frame_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: state encodings,
// parity-mode codes and data-bit limits.
package uart_rx_pkg;

  localparam logic [4:0] ST_INTERVAL  = 5'b00001;
  localparam logic [4:0] ST_STARTBIT  = 5'b00010;
  localparam logic [4:0] ST_DATABITS  = 5'b00100;
  localparam logic [4:0] ST_PARITYBIT = 5'b01000;
  localparam logic [4:0] ST_STOPBIT   = 5'b10000;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  function automatic logic [3:0] clamp_bits(
    input logic [3:0] d,
    input int         mx
  );
    if (int'(d) < DATA_BITS_MIN) return 4'(DATA_BITS_MIN);
    if (int'(d) > mx) return 4'(mx);
    return d;
  endfunction

endpackage

// File: rtl/uart_tmr_vote.sv
// Bitwise 2-of-3 majority voter used by the triplicated
// frame controller build.
module uart_tmr_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_rx_frame_fsm.sv
// UART Rx frame controller: start/data/parity/stop tracking with watchdog.
// Define UART_RX_FSM_TMR_EN to triplicate state and counters.
module uart_rx_frame_fsm
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int CNT_W         = 4,
  parameter int TIMEOUT_TICKS = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_Enable_i,
  input  logic             Rx_Synch_i,
  input  logic             Bit_Synch_i,
  input  logic             RxBit_i,
  input  logic             StartBitErr_i,
  input  logic             AcqSig_i,
  input  logic [3:0]       DataBits_i,
  input  logic [2:0]       ParityMode_i,
  input  logic             StopBits_i,
  output logic [4:0]       State_o,
  output logic [CNT_W-1:0] BitCounter_o,
  output logic             FrameDone_o,
  output logic             ParityErr_o,
  output logic             StopErr_o,
  output logic             Timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);

  logic [4:0]       st;
  logic [4:0]       st_nx;
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] bcnt_nx;
  logic             scnt;
  logic             scnt_nx;

  logic [3:0]       cfg_bits;
  logic [2:0]       cfg_par;
  logic             cfg_stop2;
  logic             acc;
  logic             perr;
  logic             serr;
  logic [WD_W-1:0]  wd;

  logic             latch;
  logic             done;
  logic             tout;
  logic             acc_tgl;
  logic             perr_set;
  logic             serr_set;
  logic             wd_hit;
  logic             last_bit;
  logic             last_stop;
  logic             exp_par;

`ifdef UART_RX_FSM_TMR_EN
  logic [4:0]       st_a, st_b, st_c;
  logic [CNT_W-1:0] bcnt_a, bcnt_b, bcnt_c;
  logic             scnt_a, scnt_b, scnt_c;

  // every copy reloads from the voted next value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_a   <= ST_INTERVAL;
      st_b   <= ST_INTERVAL;
      st_c   <= ST_INTERVAL;
      bcnt_a <= '0;
      bcnt_b <= '0;
      bcnt_c <= '0;
      scnt_a <= 1'b0;
      scnt_b <= 1'b0;
      scnt_c <= 1'b0;
    end else begin
      st_a   <= st_nx;
      st_b   <= st_nx;
      st_c   <= st_nx;
      bcnt_a <= bcnt_nx;
      bcnt_b <= bcnt_nx;
      bcnt_c <= bcnt_nx;
      scnt_a <= scnt_nx;
      scnt_b <= scnt_nx;
      scnt_c <= scnt_nx;
    end
  end

  uart_tmr_vote #(.W(5)) u_vote_st (
    .a(st_a), .b(st_b), .c(st_c), .y(st)
  );
  uart_tmr_vote #(.W(CNT_W)) u_vote_bcnt (
    .a(bcnt_a), .b(bcnt_b), .c(bcnt_c), .y(bcnt)
  );
  uart_tmr_vote #(.W(1)) u_vote_scnt (
    .a(scnt_a), .b(scnt_b), .c(scnt_c), .y(scnt)
  );
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= ST_INTERVAL;
      bcnt <= '0;
      scnt <= 1'b0;
    end else begin
      st   <= st_nx;
      bcnt <= bcnt_nx;
      scnt <= scnt_nx;
    end
  end
`endif

  assign last_bit  = int'(bcnt) == int'(cfg_bits) - 1;
  assign last_stop = scnt == cfg_stop2;
  assign wd_hit    = AcqSig_i && wd == WD_W'(TIMEOUT_TICKS - 1);

  always_comb begin
    exp_par = acc;
    case (cfg_par)
      PAR_ODD:   exp_par = ~acc;
      PAR_MARK:  exp_par = 1'b1;
      PAR_SPACE: exp_par = 1'b0;
      default:   exp_par = acc;
    endcase
  end

  always_comb begin
    st_nx    = st;
    bcnt_nx  = bcnt;
    scnt_nx  = scnt;
    latch    = 1'b0;
    done     = 1'b0;
    tout     = 1'b0;
    acc_tgl  = 1'b0;
    perr_set = 1'b0;
    serr_set = 1'b0;
    case (st)
      ST_INTERVAL: begin
        if (p_Enable_i && Rx_Synch_i) begin
          st_nx = ST_STARTBIT;
          latch = 1'b1;
        end
      end
      ST_STARTBIT: begin
        if (Bit_Synch_i)
          st_nx = StartBitErr_i ? ST_INTERVAL : ST_DATABITS;
      end
      ST_DATABITS: begin
        if (Bit_Synch_i) begin
          acc_tgl = RxBit_i;
          if (last_bit)
            st_nx = (cfg_par == PAR_NONE) ? ST_STOPBIT : ST_PARITYBIT;
          else
            bcnt_nx = bcnt + CNT_W'(1);
        end
      end
      ST_PARITYBIT: begin
        if (Bit_Synch_i) begin
          perr_set = RxBit_i != exp_par;
          st_nx    = ST_STOPBIT;
        end
      end
      ST_STOPBIT: begin
        // a new start edge ends the frame, the open stop bit counts good
        if (last_stop && p_Enable_i && Rx_Synch_i) begin
          st_nx = ST_STARTBIT;
          latch = 1'b1;
          done  = 1'b1;
        end else if (Bit_Synch_i) begin
          serr_set = !RxBit_i;
          if (last_stop) begin
            st_nx = ST_INTERVAL;
            done  = 1'b1;
          end else begin
            scnt_nx = 1'b1;
          end
        end
      end
      default: st_nx = ST_INTERVAL;
    endcase
    if (st != ST_INTERVAL && wd_hit) begin
      st_nx = ST_INTERVAL;
      tout  = 1'b1;
      done  = 1'b0;
      latch = 1'b0;
    end
    if (!p_Enable_i) begin
      st_nx = ST_INTERVAL;
      tout  = 1'b0;
      done  = 1'b0;
      latch = 1'b0;
    end
    if (st_nx != ST_DATABITS) bcnt_nx = '0;
    if (st_nx != ST_STOPBIT) scnt_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_bits    <= 4'(DATA_BITS_MIN);
      cfg_par     <= PAR_NONE;
      cfg_stop2   <= 1'b0;
      acc         <= 1'b0;
      perr        <= 1'b0;
      serr        <= 1'b0;
      wd          <= '0;
      FrameDone_o <= 1'b0;
      ParityErr_o <= 1'b0;
      StopErr_o   <= 1'b0;
      Timeout_o   <= 1'b0;
    end else begin
      if (latch) begin
        cfg_bits  <= clamp_bits(DataBits_i, MAX_DATA_BITS);
        cfg_par   <= (ParityMode_i > PAR_SPACE) ? PAR_NONE : ParityMode_i;
        cfg_stop2 <= StopBits_i;
      end
      if (latch || st_nx == ST_INTERVAL) begin
        acc  <= 1'b0;
        perr <= 1'b0;
        serr <= 1'b0;
      end else begin
        acc  <= acc ^ acc_tgl;
        perr <= perr | perr_set;
        serr <= serr | serr_set;
      end
      if (st == ST_INTERVAL || st_nx != st || Bit_Synch_i)
        wd <= '0;
      else if (AcqSig_i && wd != WD_W'(TIMEOUT_TICKS))
        wd <= wd + WD_W'(1);
      FrameDone_o <= done;
      ParityErr_o <= done & perr;
      StopErr_o   <= done & (serr | serr_set);
      Timeout_o   <= tout;
    end
  end

  assign State_o      = st;
  assign BitCounter_o = bcnt;

endmodule

// File: tb/tb_uart_rx_frame_fsm.sv
// Directed bench for uart_rx_frame_fsm: frame vector table plus
// hand-written timeout, disable, restart and reset sequences.
module tb_uart_rx_frame_fsm;

  localparam logic [4:0] S_INT   = 5'b00001;
  localparam logic [4:0] S_START = 5'b00010;
  localparam logic [4:0] S_DATA  = 5'b00100;
  localparam logic [4:0] S_PAR   = 5'b01000;
  localparam logic [4:0] S_STOP  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       rx_synch = 1'b0;
  logic       bit_synch = 1'b0;
  logic       rx_bit = 1'b0;
  logic       sb_err = 1'b0;
  logic       acq = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic [2:0] par_mode = 3'd0;
  logic       stop_bits = 1'b0;
  logic [4:0] state;
  logic [3:0] bit_cnt;
  logic       done;
  logic       perr;
  logic       serr;
  logic       tout;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_frame_fsm #(
    .MAX_DATA_BITS(9),
    .CNT_W(4),
    .TIMEOUT_TICKS(48)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p_Enable_i(en),
    .Rx_Synch_i(rx_synch),
    .Bit_Synch_i(bit_synch),
    .RxBit_i(rx_bit),
    .StartBitErr_i(sb_err),
    .AcqSig_i(acq),
    .DataBits_i(data_bits),
    .ParityMode_i(par_mode),
    .StopBits_i(stop_bits),
    .State_o(state),
    .BitCounter_o(bit_cnt),
    .FrameDone_o(done),
    .ParityErr_o(perr),
    .StopErr_o(serr),
    .Timeout_o(tout)
  );

  typedef struct {
    logic [3:0] db;
    logic [2:0] pm;
    logic       sb;
    logic [8:0] data;
    logic       pbit;
    logic       s0;
    logic       s1;
    int         nb;
    logic       has_par;
    logic       eperr;
    logic       eserr;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_bit(input logic b);
    bit_synch = 1'b1;
    rx_bit = b;
    tick();
    bit_synch = 1'b0;
    rx_bit = 1'b0;
  endtask

  task automatic start(input logic [3:0] db, input logic [2:0] pm,
                       input logic sb);
    data_bits = db;
    par_mode = pm;
    stop_bits = sb;
    rx_synch = 1'b1;
    tick();
    rx_synch = 1'b0;
    data_bits = 4'd0;
    par_mode = 3'd7;
    stop_bits = ~sb;
  endtask

  initial begin
    v[0] = '{4'd8,  3'd0, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0};
    v[1] = '{4'd7,  3'd2, 1'b0, 9'h041, 1'b0, 1'b1, 1'b1, 7, 1'b1, 1'b1, 1'b0};
    v[2] = '{4'd7,  3'd2, 1'b0, 9'h041, 1'b1, 1'b1, 1'b1, 7, 1'b1, 1'b0, 1'b0};
    v[3] = '{4'd9,  3'd0, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0, 9, 1'b0, 1'b0, 1'b1};
    v[4] = '{4'd3,  3'd1, 1'b0, 9'h015, 1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0};
    v[5] = '{4'd12, 3'd3, 1'b0, 9'h155, 1'b0, 1'b1, 1'b1, 9, 1'b1, 1'b1, 1'b0};
    v[6] = '{4'd6,  3'd4, 1'b0, 9'h03C, 1'b1, 1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b1};
    v[7] = '{4'd5,  3'd6, 1'b0, 9'h00A, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst state", 32'(state), 32'(S_INT));
    chk("rst cnt", 32'(bit_cnt), 0);
    chk("rst pulses", {28'd0, done, perr, serr, tout}, 0);
    rst = 1'b1;
    tick();

    en = 1'b0;
    rx_synch = 1'b1;
    tick();
    rx_synch = 1'b0;
    chk("disabled start", 32'(state), 32'(S_INT));
    en = 1'b1;

    foreach (v[k]) begin
      start(v[k].db, v[k].pm, v[k].sb);
      chk($sformatf("v%0d startbit", k), 32'(state), 32'(S_START));
      pulse_bit(1'b0);
      for (int i = 0; i < v[k].nb; i++) begin
        chk($sformatf("v%0d d%0d state", k, i), 32'(state), 32'(S_DATA));
        chk($sformatf("v%0d d%0d cnt", k, i), 32'(bit_cnt), 32'(i));
        pulse_bit(v[k].data[i]);
      end
      if (v[k].has_par) begin
        chk($sformatf("v%0d par state", k), 32'(state), 32'(S_PAR));
        pulse_bit(v[k].pbit);
      end
      chk($sformatf("v%0d stop state", k), 32'(state), 32'(S_STOP));
      chk($sformatf("v%0d stop cnt", k), 32'(bit_cnt), 0);
      pulse_bit(v[k].s0);
      if (v[k].sb) begin
        chk($sformatf("v%0d stop2 state", k), 32'(state), 32'(S_STOP));
        pulse_bit(v[k].s1);
      end
      chk($sformatf("v%0d end state", k), 32'(state), 32'(S_INT));
      chk($sformatf("v%0d done", k), 32'(done), 1);
      chk($sformatf("v%0d perr", k), 32'(perr), 32'(v[k].eperr));
      chk($sformatf("v%0d serr", k), 32'(serr), 32'(v[k].eserr));
      tick();
      chk($sformatf("v%0d pulse end", k), {29'd0, done, perr, serr}, 0);
    end

    start(4'd8, 3'd0, 1'b0);
    pulse_bit(1'b0);
    for (int i = 0; i < 4; i++) pulse_bit(1'b1);
    chk("wd cnt hold", 32'(bit_cnt), 4);
    for (int i = 0; i < 47; i++) begin
      acq = 1'b1;
      tick();
      acq = 1'b0;
      tick();
    end
    chk("wd 47 state", 32'(state), 32'(S_DATA));
    chk("wd 47 tout", 32'(tout), 0);
    chk("wd 47 cnt", 32'(bit_cnt), 4);
    acq = 1'b1;
    tick();
    acq = 1'b0;
    chk("wd 48 tout", 32'(tout), 1);
    chk("wd 48 state", 32'(state), 32'(S_INT));
    chk("wd 48 cnt", 32'(bit_cnt), 0);
    chk("wd 48 done", 32'(done), 0);
    tick();
    chk("wd tout end", 32'(tout), 0);

    start(4'd8, 3'd0, 1'b0);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    pulse_bit(1'b0);
    en = 1'b0;
    tick();
    chk("dis state", 32'(state), 32'(S_INT));
    chk("dis cnt", 32'(bit_cnt), 0);
    chk("dis pulses", {30'd0, done, tout}, 0);
    en = 1'b1;
    tick();
    chk("dis after", {30'd0, done, tout}, 0);

    start(4'd8, 3'd0, 1'b0);
    pulse_bit(1'b0);
    for (int i = 0; i < 8; i++) pulse_bit(1'b1);
    chk("rs stop", 32'(state), 32'(S_STOP));
    rx_synch = 1'b1;
    bit_synch = 1'b1;
    rx_bit = 1'b0;
    data_bits = 4'd5;
    par_mode = 3'd0;
    stop_bits = 1'b0;
    tick();
    rx_synch = 1'b0;
    bit_synch = 1'b0;
    data_bits = 4'd9;
    par_mode = 3'd1;
    chk("rs state", 32'(state), 32'(S_START));
    chk("rs done", 32'(done), 1);
    chk("rs errs", {30'd0, perr, serr}, 0);
    pulse_bit(1'b0);
    for (int i = 0; i < 5; i++) pulse_bit(1'b1);
    chk("rs relatch", 32'(state), 32'(S_STOP));
    pulse_bit(1'b1);
    chk("rs2 done", 32'(done), 1);
    chk("rs2 state", 32'(state), 32'(S_INT));

    start(4'd8, 3'd0, 1'b0);
    sb_err = 1'b1;
    pulse_bit(1'b1);
    sb_err = 1'b0;
    chk("sberr state", 32'(state), 32'(S_INT));
    chk("sberr done", 32'(done), 0);
    tick();
    chk("sberr done2", 32'(done), 0);

`ifdef UART_RX_FSM_TMR_EN
    start(4'd8, 3'd0, 1'b0);
    pulse_bit(1'b0);
    force dut.st_b = 5'b01000;
    #1;
    release dut.st_b;
    chk("tmr voted", 32'(state), 32'(S_DATA));
    tick();
    chk("tmr repair", 32'(dut.st_b), 32'(S_DATA));
    chk("tmr state", 32'(state), 32'(S_DATA));
    en = 1'b0;
    tick();
    en = 1'b1;
`endif

    start(4'd8, 3'd0, 1'b0);
    pulse_bit(1'b0);
    pulse_bit(1'b1);
    rst = 1'b0;
    #1;
    chk("arst state", 32'(state), 32'(S_INT));
    chk("arst cnt", 32'(bit_cnt), 0);
    chk("arst pulses", {28'd0, done, perr, serr, tout}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst after", {28'd0, done, perr, serr, tout}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
